// File: rtl/efi_pkg.sv
// Shared EFI types: crank-engine state encoding and default period width,
// common to the VR conditioner, sync and the injector/ignition drivers.
package efi_pkg;

  localparam int PERIOD_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } efi_state_e;

endpackage

// File: rtl/vr_glitch_filter.sv
// Resynchronises an asynchronous comparator input and only lets the filtered
// level follow it after FILTER_LEN consecutive cycles of disagreement.
module vr_glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vrin,
  output logic vr_clean
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] stable_cnt;

  // The toggle fires on the FILTER_LEN-th consecutive mismatching cycle,
  // so the counter only needs to reach FILTER_LEN-1 before wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      stable_cnt <= '0;
      vr_clean   <= 1'b0;
    end else begin
      s1 <= vrin;
      s2 <= s1;
      if (s2 == vr_clean) begin
        stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
        stable_cnt <= '0;
        vr_clean   <= ~vr_clean;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vr_conditioner.sv
// Crank VR front end: glitch filter, selected-edge detect, adaptive blanking
// against the previous tooth period, period measurement and stall detection.
module vr_conditioner
  import efi_pkg::*;
#(
  parameter int                  FILTER_LEN   = 4,
  parameter int                  PERIOD_W     = PERIOD_W_DEF,
  parameter int                  BLANK_SHIFT  = 2,
  parameter logic [PERIOD_W-1:0] STALL_CYCLES = PERIOD_W'(32'd4_000_000)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vrin,
  input  logic                en,
  input  logic                edge_sel,
  output logic                vr_clean,
  output logic                tooth,
  output logic [PERIOD_W-1:0] tooth_period,
  output logic                period_valid,
  output logic                stalled,
  output logic [15:0]         reject_cnt,
  output efi_state_e          state_dbg
);

  efi_state_e          state;
  efi_state_e          state_next;
  logic                clean_d;
  logic                tooth_raw;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] blank_win;
  logic                accept;
  logic                reject;
  logic                stall_hit;
  logic                publish;

  vr_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .vrin     (vrin),
    .vr_clean (vr_clean)
  );

  // edge_sel is applied at the transition itself, so changing it between
  // transitions can never manufacture a strobe.
  assign tooth_raw = (vr_clean != clean_d) && (vr_clean == ~edge_sel);
  assign blank_win = tooth_period >> BLANK_SHIFT;
  assign publish   = accept && (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      clean_d <= 1'b0;
    end else begin
      state   <= state_next;
      clean_d <= vr_clean;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    stall_hit  = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tooth_raw) begin
            accept     = 1'b1;
            state_next = ST_FIRST;
          end
        end
        ST_FIRST, ST_RUN: begin
          // Stall wins over a coincident edge; that edge is dropped.
          if (cnt >= STALL_CYCLES) begin
            stall_hit  = 1'b1;
            state_next = ST_IDLE;
          end else if (tooth_raw && (state == ST_RUN) && (cnt < blank_win)) begin
            reject = 1'b1;
          end else if (tooth_raw) begin
            accept     = 1'b1;
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // tooth is a one-cycle strobe; tooth_period/period_valid are already
  // updated in that same cycle, so a consumer samples all three together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      tooth_period <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      tooth        <= 1'b0;
      reject_cnt   <= '0;
    end else if (!en) begin
      cnt          <= '0;
      tooth_period <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      tooth        <= 1'b0;
    end else begin
      tooth <= accept;
      if (accept) begin
        cnt <= PERIOD_W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + PERIOD_W'(1);
      end
      if (accept && (state == ST_IDLE)) begin
        stalled <= 1'b0;
      end
      if (publish) begin
        tooth_period <= cnt;
        period_valid <= 1'b1;
      end
      if (stall_hit) begin
        stalled      <= 1'b1;
        period_valid <= 1'b0;
      end
      if (reject && (reject_cnt != 16'hFFFF)) begin
        reject_cnt <= reject_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vr_conditioner.sv
// Bench for vr_conditioner: event-level reference model plus directed and
// randomized scenarios.
module tb_vr_conditioner;
  import efi_pkg::*;

  localparam int STALL = 1000;
  localparam int FL    = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vrin;
  logic        en;
  logic        edge_sel;
  logic        vr_clean;
  logic        tooth;
  logic [31:0] tooth_period;
  logic        period_valid;
  logic        stalled;
  logic [15:0] reject_cnt;
  efi_state_e  state_dbg;

  int total = 0;
  int bad   = 0;
  int mon_err   = 0;
  int sb_err    = 0;
  int dut_teeth = 0;
  logic [31:0] exp_q[$];

  vr_conditioner #(.STALL_CYCLES(32'd1000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vrin         (vrin),
    .en           (en),
    .edge_sel     (edge_sel),
    .vr_clean     (vr_clean),
    .tooth        (tooth),
    .tooth_period (tooth_period),
    .period_valid (period_valid),
    .stalled      (stalled),
    .reject_cnt   (reject_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Filtered level follows vrin once FL consecutive synchronised samples
  // disagree with it; teeth are scored by time since the last accepted tooth.
  int         k = 0;
  int         last_acc = 0;
  efi_state_e m_state = ST_IDLE;
  logic       m_clean = 1'b0;
  logic       pend = 1'b0;
  logic       pend_lvl = 1'b0;
  logic       m_tooth = 1'b0;
  logic       m_pv = 1'b0;
  logic       m_stalled = 1'b0;
  logic [31:0] m_tp = '0;
  logic [15:0] m_rej = '0;
  logic        hist[$];

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (reset_n !== 1'b1) begin
        m_state = ST_IDLE; m_clean = 1'b0; pend = 1'b0; pend_lvl = 1'b0;
        m_tooth = 1'b0; m_pv = 1'b0; m_stalled = 1'b0; m_tp = '0; m_rej = '0;
        exp_q.delete();
        hist.delete();
        for (int j = 0; j < FL + 2; j++) hist.push_back(1'b0);
      end else begin
        int   since;
        logic raw;
        logic all_diff;
        k++;
        since   = k - last_acc;
        raw     = pend && (pend_lvl != edge_sel);
        m_tooth = 1'b0;
        if (!en) begin
          m_state = ST_IDLE; m_tp = '0; m_pv = 1'b0; m_stalled = 1'b0;
        end else if (m_state != ST_IDLE && since >= STALL) begin
          m_stalled = 1'b1; m_pv = 1'b0; m_state = ST_IDLE;
        end else if (raw) begin
          if (m_state == ST_RUN && since < int'(m_tp >> 2)) begin
            if (m_rej != 16'hFFFF) m_rej = m_rej + 16'd1;
          end else begin
            m_tooth = 1'b1;
            if (m_state == ST_IDLE) begin
              m_stalled = 1'b0;
              m_state   = ST_FIRST;
            end else begin
              m_tp    = since;
              m_pv    = 1'b1;
              m_state = ST_RUN;
              exp_q.push_back(since);
            end
            last_acc = k;
          end
        end
        hist.push_back(vrin);
        all_diff = 1'b1;
        for (int j = 2; j < FL + 2; j++)
          if (hist[hist.size() - 1 - j] == m_clean) all_diff = 1'b0;
        pend = 1'b0;
        if (all_diff) begin
          m_clean  = ~m_clean;
          pend     = 1'b1;
          pend_lvl = m_clean;
        end
        void'(hist.pop_front());
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (vr_clean !== m_clean || tooth !== m_tooth || tooth_period !== m_tp ||
          period_valid !== m_pv || stalled !== m_stalled ||
          reject_cnt !== m_rej || state_dbg !== m_state)
        mon_err++;
      if (tooth === 1'b1) begin
        dut_teeth++;
        if (period_valid === 1'b1) begin
          if (exp_q.size() == 0) sb_err++;
          else if (exp_q.pop_front() !== tooth_period) sb_err++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic hold(input logic lvl, input int n);
    vrin = lvl;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b0; vrin = 1'b0; en = 1'b0; edge_sel = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (vr_clean !== 1'b0) begin bad++; $display("FAIL reset_vr_clean got=%0b want=0", vr_clean); end
    total++; if (tooth !== 1'b0) begin bad++; $display("FAIL reset_tooth got=%0b want=0", tooth); end
    total++; if (tooth_period !== 32'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", tooth_period); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL reset_pv got=%0b want=0", period_valid); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL reset_stalled got=%0b want=0", stalled); end
    total++; if (reject_cnt !== 16'd0) begin bad++; $display("FAIL reset_rej got=%0d want=0", reject_cnt); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, ST_IDLE); end
    en = 1'b1;
    hold(1'b0, 20);
  endtask

  task automatic test_square;
    int lat = 0;
    int t0 = dut_teeth;
    vrin = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tooth === 1'b1 && lat == 0) lat = i;
    end
    total++; if (lat != 7) begin bad++; $display("FAIL first_tooth_latency got=%0d want=7", lat); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL pv_after_first got=%0b want=0", period_valid); end
    hold(1'b1, 30);
    for (int p = 0; p < 5; p++) begin
      hold(1'b0, 50);
      hold(1'b1, 50);
    end
    total++; if (dut_teeth - t0 != 6) begin bad++; $display("FAIL square_teeth got=%0d want=6", dut_teeth - t0); end
    total++; if (tooth_period !== 32'd100) begin bad++; $display("FAIL square_period got=%0d want=100", tooth_period); end
    total++; if (period_valid !== 1'b1) begin bad++; $display("FAIL square_pv got=%0b want=1", period_valid); end
    total++; if (mon_err != 0) begin bad++; $display("FAIL square_model got=%0d want=0", mon_err); end
  endtask

  task automatic test_glitch;
    int t0 = dut_teeth;
    for (int p = 0; p < 4; p++) begin
      int a = $urandom_range(10, 35);
      int b = $urandom_range(10, 35);
      hold(1'b0, a);
      hold(1'b1, 3);
      hold(1'b0, 8);
      total++; if (vr_clean !== 1'b0) begin bad++; $display("FAIL glitch_level got=%0b want=0", vr_clean); end
      hold(1'b0, 50 - a - 11);
      hold(1'b1, b);
      hold(1'b0, 3);
      hold(1'b1, 50 - b - 3);
    end
    total++; if (dut_teeth - t0 != 4) begin bad++; $display("FAIL glitch_teeth got=%0d want=4", dut_teeth - t0); end
    total++; if (reject_cnt !== 16'd0) begin bad++; $display("FAIL glitch_rej got=%0d want=0", reject_cnt); end
    total++; if (tooth_period !== 32'd100) begin bad++; $display("FAIL glitch_period got=%0d want=100", tooth_period); end
  endtask

  task automatic test_blank;
    int t0 = dut_teeth;
    int p = $urandom_range(15, 18);
    hold(1'b0, 50);
    hold(1'b1, p);
    hold(1'b0, 6);
    hold(1'b1, 50 - p - 6);
    hold(1'b0, 50);
    hold(1'b1, 50);
    total++; if (reject_cnt !== 16'd1) begin bad++; $display("FAIL blank_rej got=%0d want=1", reject_cnt); end
    total++; if (dut_teeth - t0 != 2) begin bad++; $display("FAIL blank_teeth got=%0d want=2", dut_teeth - t0); end
    total++; if (tooth_period !== 32'd100) begin bad++; $display("FAIL blank_period got=%0d want=100", tooth_period); end
  endtask

  task automatic test_stall;
    int t0;
    int s = $urandom_range(80, 140);
    hold(1'b0, 1100);
    total++; if (stalled !== 1'b1) begin bad++; $display("FAIL stall_flag got=%0b want=1", stalled); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL stall_pv got=%0b want=0", period_valid); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL stall_state got=%0d want=%0d", state_dbg, ST_IDLE); end
    t0 = dut_teeth;
    hold(1'b1, 40);
    total++; if (dut_teeth - t0 != 1) begin bad++; $display("FAIL restart_teeth got=%0d want=1", dut_teeth - t0); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL restart_stall got=%0b want=0", stalled); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL restart_pv got=%0b want=0", period_valid); end
    hold(1'b0, s - 40);
    hold(1'b1, 40);
    hold(1'b0, 40);
    total++; if (period_valid !== 1'b1) begin bad++; $display("FAIL restore_pv got=%0b want=1", period_valid); end
    total++; if (tooth_period !== 32'(s)) begin bad++; $display("FAIL restore_period got=%0d want=%0d", tooth_period, s); end
  endtask

  task automatic test_edge_sel;
    int lat = 0;
    edge_sel = 1'b1;
    for (int p = 0; p < 4; p++) begin
      hold(1'b1, 30);
      hold(1'b0, 70);
    end
    hold(1'b1, 30);
    vrin = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tooth === 1'b1 && lat == 0) lat = i;
    end
    hold(1'b0, 50);
    total++; if (lat != 7) begin bad++; $display("FAIL fall_latency got=%0d want=7", lat); end
    total++; if (tooth_period !== 32'd100) begin bad++; $display("FAIL fall_period got=%0d want=100", tooth_period); end
    total++; if (period_valid !== 1'b1) begin bad++; $display("FAIL fall_pv got=%0b want=1", period_valid); end
    en = 1'b0;
    @(negedge clk);
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL en_pv got=%0b want=0", period_valid); end
    total++; if (tooth_period !== 32'd0) begin bad++; $display("FAIL en_period got=%0d want=0", tooth_period); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL en_state got=%0d want=%0d", state_dbg, ST_IDLE); end
    en = 1'b1;
  endtask

  task automatic test_reset_mid;
    for (int p = 0; p < 2; p++) begin
      hold(1'b1, 30);
      hold(1'b0, 70);
    end
    hold(1'b1, 20);
    #2 reset_n = 1'b0;
    #1;
    total++; if (vr_clean !== 1'b0) begin bad++; $display("FAIL async_vr_clean got=%0b want=0", vr_clean); end
    total++; if (tooth_period !== 32'd0) begin bad++; $display("FAIL async_period got=%0d want=0", tooth_period); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL async_pv got=%0b want=0", period_valid); end
    total++; if (reject_cnt !== 16'd0) begin bad++; $display("FAIL async_rej got=%0d want=0", reject_cnt); end
    total++; if (tooth !== 1'b0 || stalled !== 1'b0) begin bad++; $display("FAIL async_flags got=%0b%0b want=00", tooth, stalled); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    edge_sel = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 8) edge_sel = ~edge_sel;
      if (r >= 8 && r < 12) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        en = 1'b1;
      end
      if (r >= 97) hold(vrin, 1050);
      else hold(1'($urandom_range(0, 1)), $urandom_range(1, 60));
    end
    hold(1'b0, 10);
    total++; if (mon_err != 0) begin bad++; $display("FAIL model_cycles got=%0d want=0", mon_err); end
    total++; if (sb_err != 0) begin bad++; $display("FAIL period_scoreboard got=%0d want=0", sb_err); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL missing_teeth got=%0d want=0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_square();
    test_glitch();
    test_blank();
    test_stall();
    test_edge_sel();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
